// File: rtl/playback_sequencer.sv
// rtl/playback_sequencer.sv - run-control FSM with programmable tick divider stepping an address range
module playback_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int DIV_W    = 24,
    parameter int TICK_DIV = 12_500_000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Pause,
    input  logic              Loop,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [ADDR_W-1:0] EndAddr,
    input  logic [1:0]        RateSel,
    output logic [ADDR_W-1:0] Addr,
    output logic              Step,
    output logic              Busy,
    output logic              Done,
    output logic [1:0]        State
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] BASE_DIV = DIV_W'(TICK_DIV);

    state_t            state;
    logic [DIV_W-1:0]  count;
    logic [ADDR_W-1:0] start_lat;
    logic [ADDR_W-1:0] end_lat;
    logic [1:0]        rate_lat;
    logic [DIV_W-1:0]  shifted;
    logic [DIV_W-1:0]  last_count;

    // A period that shifts down to zero is clamped to one cycle.
    always_comb begin
        shifted    = BASE_DIV >> rate_lat;
        last_count = (shifted == '0) ? '0 : shifted - 1'b1;
    end

    assign State = state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            start_lat <= '0;
            end_lat   <= '0;
            rate_lat  <= '0;
            Addr      <= '0;
            Step      <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Step <= 1'b0;
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && !Stop) begin
                        start_lat <= StartAddr;
                        end_lat   <= EndAddr;
                        rate_lat  <= RateSel;
                        Addr      <= StartAddr;
                        count     <= '0;
                        Busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                // Resuming from PAUSE counts on the same edge, so a pause costs exactly its length.
                RUN, PAUSE: begin
                    if (Stop) begin
                        count <= '0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else if (Pause) begin
                        state <= PAUSE;
                    end else begin
                        state <= RUN;
                        if (count == last_count) begin
                            count <= '0;
                            Step  <= 1'b1;
                            if (Addr != end_lat) begin
                                Addr <= Addr + 1'b1;
                            end else if (Loop) begin
                                Addr <= start_lat;
                            end else begin
                                Busy  <= 1'b0;
                                Done  <= 1'b1;
                                state <= DONE;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_playback_sequencer.sv
// tb/tb_playback_sequencer.sv - directed self-checking bench for playback_sequencer
module tb_playback_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic       Pause = 1'b0;
    logic       Loop = 1'b0;
    logic [3:0] StartAddr = '0;
    logic [3:0] EndAddr = '0;
    logic [1:0] RateSel = '0;
    logic [3:0] Addr;
    logic       Step;
    logic       Busy;
    logic       Done;
    logic [1:0] State;

    int checks = 0;
    int passed = 0;
    int n;

    playback_sequencer #(.ADDR_W(4), .DIV_W(24), .TICK_DIV(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Pause(Pause),
        .Loop(Loop), .StartAddr(StartAddr), .EndAddr(EndAddr), .RateSel(RateSel),
        .Addr(Addr), .Step(Step), .Busy(Busy), .Done(Done), .State(State)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge Clk);
    endtask

    task automatic start_run(input logic [3:0] sa, input logic [3:0] ea,
                             input logic [1:0] rs, input logic lp);
        StartAddr = sa; EndAddr = ea; RateSel = rs; Loop = lp; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_step(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            cnt++;
            if (Step) break;
        end
        if (!Step) check("step_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // reset state
        #1;
        check("rst_state", State, 2'b00);
        check("rst_addr", Addr, 4'd0);
        check("rst_flags", {Step, Busy, Done}, 3'b000);
        cyc(2);
        Reset = 1'b0;
        cyc(1);

        // 1: single run 2..4
        start_run(4'd2, 4'd4, 2'd0, 1'b0);
        check("t1_state", State, 2'b01);
        check("t1_addr0", Addr, 4'd2);
        check("t1_busy", Busy, 1'b1);
        wait_step(n); check("t1_p1", n, 8); check("t1_a1", Addr, 4'd3);
        wait_step(n); check("t1_p2", n, 8); check("t1_a2", Addr, 4'd4);
        wait_step(n); check("t1_p3", n, 8);
        check("t1_done", {Done, Busy, State}, 4'b1011);
        check("t1_hold", Addr, 4'd4);
        cyc(1);
        check("t1_idle", {Done, Busy, State}, 4'b0000);
        check("t1_addr_end", Addr, 4'd4);

        // 2: looping run
        start_run(4'd2, 4'd4, 2'd0, 1'b1);
        wait_step(n); check("t2_a1", Addr, 4'd3);
        wait_step(n); check("t2_a2", Addr, 4'd4);
        wait_step(n); check("t2_p3", n, 8); check("t2_wrap", Addr, 4'd2);
        check("t2_busy", {Done, Busy}, 2'b01);
        wait_step(n); check("t2_a4", Addr, 4'd3);

        // 3: pause for 5 cycles when count is 3
        cyc(3);
        Pause = 1'b1;
        cyc(5);
        check("t3_state", State, 2'b10);
        check("t3_addr", Addr, 4'd3);
        Pause = 1'b0;
        wait_step(n); check("t3_gap", 3 + 5 + n, 13); check("t3_a", Addr, 4'd4);

        // 6a: stop mid-run
        cyc(2);
        Stop = 1'b1;
        cyc(1);
        Stop = 1'b0;
        check("t6_stop", {Done, Busy, State}, 4'b0000);
        check("t6_hold", Addr, 4'd4);

        // 4: faster rates; mid-run RateSel change ignored
        start_run(4'd0, 4'd15, 2'd2, 1'b1);
        wait_step(n); check("t4_p2a", n, 2); check("t4_a1", Addr, 4'd1);
        RateSel = 2'd0;
        wait_step(n); check("t4_p2b", n, 2); check("t4_a2", Addr, 4'd2);
        wait_step(n); check("t4_p2c", n, 2);
        Stop = 1'b1; cyc(1); Stop = 1'b0;
        start_run(4'd5, 4'd7, 2'd3, 1'b0);
        wait_step(n); check("t4_p1a", n, 1); check("t4_b1", Addr, 4'd6);
        wait_step(n); check("t4_p1b", n, 1); check("t4_b2", Addr, 4'd7);
        wait_step(n); check("t4_p1c", n, 1); check("t4_bdone", {Done, State}, 3'b111);
        cyc(1);

        // 5: wrap through 0, Start ignored during run
        start_run(4'd14, 4'd1, 2'd0, 1'b0);
        wait_step(n); check("t5_a1", Addr, 4'd15);
        StartAddr = 4'd5; RateSel = 2'd3; Start = 1'b1;
        cyc(1);
        Start = 1'b0;
        check("t5_ign", {State, Addr}, {2'b01, 4'd15});
        wait_step(n); check("t5_p2", n, 7); check("t5_a2", Addr, 4'd0);
        wait_step(n); check("t5_a3", Addr, 4'd1);
        wait_step(n); check("t5_done", {Done, State, Addr}, {1'b1, 2'b11, 4'd1});
        cyc(1);

        // 6b: Start and Stop together in IDLE
        StartAddr = 4'd9; Start = 1'b1; Stop = 1'b1;
        cyc(1);
        Start = 1'b0; Stop = 1'b0;
        check("t6_both", {Busy, State, Addr}, {1'b0, 2'b00, 4'd1});

        // 6c: async reset between edges
        start_run(4'd2, 4'd4, 2'd0, 1'b0);
        cyc(3);
        #2 Reset = 1'b1;
        #1 check("t6_async", {Addr, Step, Busy, Done, State}, 9'd0);
        #1 Reset = 1'b0;
        cyc(1);

        // single-address run at P=1 after reset
        start_run(4'd3, 4'd3, 2'd3, 1'b0);
        wait_step(n); check("t7_p", n, 1);
        check("t7_done", {Done, State, Addr}, {1'b1, 2'b11, 4'd3});
        cyc(1);
        check("t7_idle", State, 2'b00);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
